// File: rtl/pcpi_vec_mem_arbiter.sv
// Shares one native picorv32-style memory port between the CPU and the vector
// coprocessor: one word transaction at a time, fixed priority with a starvation guard.
module pcpi_vec_mem_arbiter #(
  parameter bit          VEC_PRIORITY = 1'b1,
  parameter logic [3:0]  MAX_CONSEC   = 4'd4,
  parameter logic [31:0] ADDR_LIMIT   = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_valid,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        oor_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        owner_vec_r;
  logic [3:0]  consec_cnt_r;

  logic        any_valid_s;
  logic        pref_valid_s;
  logic        other_valid_s;
  logic        pref_wins_s;
  logic        grant_vec_s;
  logic        grant_oor_s;
  logic [31:0] grant_addr_s;
  logic [31:0] grant_wdata_s;
  logic [3:0]  grant_wstrb_s;
  logic [3:0]  consec_nxt_s;

  // Arbitration decision and granted-request mux; only consumed in IDLE
  always_comb begin
    any_valid_s   = cpu_mem_valid | vec_mem_valid;
    pref_valid_s  = VEC_PRIORITY ? vec_mem_valid : cpu_mem_valid;
    other_valid_s = VEC_PRIORITY ? cpu_mem_valid : vec_mem_valid;
    // The waiting master takes over once the preferred one has used up its streak
    if (pref_valid_s && other_valid_s) begin
      pref_wins_s = (consec_cnt_r != MAX_CONSEC);
    end else begin
      pref_wins_s = pref_valid_s;
    end
    grant_vec_s = VEC_PRIORITY ? pref_wins_s : ~pref_wins_s;
    if (grant_vec_s) begin
      grant_addr_s  = vec_mem_addr;
      grant_wdata_s = vec_mem_wdata;
      grant_wstrb_s = vec_mem_wstrb;
    end else begin
      grant_addr_s  = cpu_mem_addr;
      grant_wdata_s = cpu_mem_wdata;
      grant_wstrb_s = cpu_mem_wstrb;
    end
    grant_oor_s = (grant_addr_s >= ADDR_LIMIT);
    if (pref_wins_s && other_valid_s) begin
      consec_nxt_s = (consec_cnt_r >= MAX_CONSEC) ? MAX_CONSEC : consec_cnt_r + 4'd1;
    end else begin
      consec_nxt_s = 4'd0;
    end
  end

  // Next-state logic of the transaction sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_valid_s) begin
          state_nxt_s = grant_oor_s ? RESP : ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, arbitration history and every registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      owner_vec_r   <= 1'b0;
      consec_cnt_r  <= 4'd0;
      m_valid       <= 1'b0;
      m_addr        <= 32'd0;
      m_wdata       <= 32'd0;
      m_wstrb       <= 4'd0;
      cpu_mem_ready <= 1'b0;
      vec_mem_ready <= 1'b0;
      cpu_mem_rdata <= 32'd0;
      vec_mem_rdata <= 32'd0;
      oor_err       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cpu_mem_ready <= 1'b0;
      vec_mem_ready <= 1'b0;
      oor_err       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            owner_vec_r  <= grant_vec_s;
            consec_cnt_r <= consec_nxt_s;
            // Out-of-range requests complete here and never reach memory
            if (grant_oor_s) begin
              oor_err <= 1'b1;
              if (grant_vec_s) begin
                vec_mem_ready <= 1'b1;
                vec_mem_rdata <= 32'd0;
              end else begin
                cpu_mem_ready <= 1'b1;
                cpu_mem_rdata <= 32'd0;
              end
            end else begin
              m_valid <= 1'b1;
              m_addr  <= grant_addr_s;
              m_wdata <= grant_wdata_s;
              m_wstrb <= grant_wstrb_s;
            end
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (owner_vec_r) begin
              vec_mem_ready <= 1'b1;
              vec_mem_rdata <= m_rdata;
            end else begin
              cpu_mem_ready <= 1'b1;
              cpu_mem_rdata <= m_rdata;
            end
          end
        end
        RESP:    begin end
        default: begin end
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_vec_mem_arbiter.sv
// Bench for pcpi_vec_mem_arbiter: directed scenarios with hand-computed values, then
// random two-master traffic compared every cycle against a transaction schedule model.
module tb_pcpi_vec_mem_arbiter;
  localparam bit          VEC_PRI = 1'b1;
  localparam logic [3:0]  MAXC    = 4'd4;
  localparam logic [31:0] LIMIT   = 32'd1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_valid, vec_mem_valid, cpu_mem_ready, vec_mem_ready;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
  logic [31:0] vec_mem_addr, vec_mem_wdata, vec_mem_rdata;
  logic [3:0]  cpu_mem_wstrb, vec_mem_wstrb, m_wstrb;
  logic        m_valid, m_ready, oor_err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  pcpi_vec_mem_arbiter #(.VEC_PRIORITY(VEC_PRI), .MAX_CONSEC(MAXC), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr), .vec_mem_wdata(vec_mem_wdata),
    .vec_mem_wstrb(vec_mem_wstrb), .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct packed { bit is_vec; int start; int done; logic [31:0] rdata; bit oor; } done_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Masters (index 0 = CPU, 1 = vec) and their completion log
  req_t  q_cpu[$];
  req_t  q_vec[$];
  bit    m_act[2];
  req_t  m_cur[2];
  int    m_start[2];
  done_t dlog[$];
  bit    rst_req = 1'b1;
  bit    saw_mvalid = 1'b0;

  // Downstream memory responder
  logic [31:0] mem [256];
  int   mem_cnt = 0;
  int   mem_delay = 1;
  bit   mem_rand = 1'b0;
  bit   mem_noise = 1'b0;
  req_t mem_req;

  // Reference model: schedule of grants and completions plus its own memory image
  logic [31:0] ref_mem [256];
  bit          md_wait = 1'b0;
  int          md_next_arb = 0;
  int          md_streak = 0;
  bit          md_owner_vec = 1'b0;
  req_t        md_req;
  logic        e_mvalid = 1'b0, e_cpu_rdy = 1'b0, e_vec_rdy = 1'b0, e_oor = 1'b0;
  logic [31:0] e_cpu_rdata = 32'd0, e_vec_rdata = 32'd0, e_maddr = 32'd0, e_mwdata = 32'd0;
  logic [3:0]  e_mwstrb = 4'd0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    if ($urandom_range(0, 7) == 0) r.addr = {20'd0, 10'($urandom_range(256, 1023)), 2'b00};
    else                           r.addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    r.wdata = $urandom;
    r.wstrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic md_deliver(input logic [31:0] v);
    if (md_owner_vec) begin
      e_vec_rdy   = 1'b1;
      e_vec_rdata = v;
    end else begin
      e_cpu_rdy   = 1'b1;
      e_cpu_rdata = v;
    end
  endtask

  // Work out the outputs for the next cycle from this cycle's inputs
  task automatic model_update();
    bit pref_v, other_v, pref_won;
    e_cpu_rdy = 1'b0; e_vec_rdy = 1'b0; e_oor = 1'b0;
    if (rst_req) begin
      e_mvalid = 1'b0; e_cpu_rdata = 32'd0; e_vec_rdata = 32'd0;
      e_maddr = 32'd0; e_mwdata = 32'd0; e_mwstrb = 4'd0;
      md_wait = 1'b0; md_streak = 0; md_next_arb = cyc + 1;
    end else if (md_wait) begin
      if (m_ready) begin
        md_deliver(ref_mem[md_req.addr[9:2]]);
        ref_mem[md_req.addr[9:2]] = merge(ref_mem[md_req.addr[9:2]], md_req.wdata, md_req.wstrb);
        e_mvalid = 1'b0; md_wait = 1'b0; md_next_arb = cyc + 2;
      end
    end else if (cyc >= md_next_arb && (cpu_mem_valid || vec_mem_valid)) begin
      pref_v  = VEC_PRI ? vec_mem_valid : cpu_mem_valid;
      other_v = VEC_PRI ? cpu_mem_valid : vec_mem_valid;
      pref_won = (pref_v && other_v) ? (md_streak < int'(MAXC)) : pref_v;
      if (pref_won && other_v) md_streak = (md_streak < int'(MAXC)) ? md_streak + 1 : int'(MAXC);
      else                     md_streak = 0;
      md_owner_vec = (pref_won == VEC_PRI);
      md_req = md_owner_vec ? m_cur[1] : m_cur[0];
      if (md_req.addr >= LIMIT) begin
        md_deliver(32'd0);
        e_oor = 1'b1;
        md_next_arb = cyc + 2;
      end else begin
        md_wait = 1'b1; e_mvalid = 1'b1;
        e_maddr = md_req.addr; e_mwdata = md_req.wdata; e_mwstrb = md_req.wstrb;
      end
    end
  endtask

  // One clock cycle: compare, react as masters and memory, then advance the model
  task automatic step();
    @(negedge clk);
    chk("m_valid", {31'd0, m_valid}, {31'd0, e_mvalid});
    chk("cpu_ready", {31'd0, cpu_mem_ready}, {31'd0, e_cpu_rdy});
    chk("vec_ready", {31'd0, vec_mem_ready}, {31'd0, e_vec_rdy});
    chk("oor_err", {31'd0, oor_err}, {31'd0, e_oor});
    chk("cpu_rdata", cpu_mem_rdata, e_cpu_rdata);
    chk("vec_rdata", vec_mem_rdata, e_vec_rdata);
    chk("m_addr", m_addr, e_maddr);
    chk("m_wdata", m_wdata, e_mwdata);
    chk("m_wstrb", {28'd0, m_wstrb}, {28'd0, e_mwstrb});
    if (m_valid === 1'b1) saw_mvalid = 1'b1;
    if (m_act[0] && cpu_mem_ready === 1'b1) begin
      dlog.push_back('{1'b0, m_start[0], cyc, cpu_mem_rdata, oor_err});
      m_act[0] = 1'b0;
    end
    if (m_act[1] && vec_mem_ready === 1'b1) begin
      dlog.push_back('{1'b1, m_start[1], cyc, vec_mem_rdata, oor_err});
      m_act[1] = 1'b0;
    end
    m_ready = 1'b0;
    m_rdata = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        m_ready = 1'b1;
        m_rdata = mem[mem_req.addr[9:2]];
        mem[mem_req.addr[9:2]] = merge(mem[mem_req.addr[9:2]], mem_req.wdata, mem_req.wstrb);
      end
    end else if (m_valid === 1'b1) begin
      mem_req = '{m_addr, m_wdata, m_wstrb};
      mem_cnt = mem_rand ? int'($urandom_range(1, 3)) : mem_delay;
    end else if (mem_noise && $urandom_range(0, 7) == 0) begin
      m_ready = 1'b1;
    end
    reset = rst_req;
    if (rst_req) begin
      m_act[0] = 1'b0; m_act[1] = 1'b0;
    end else begin
      if (!m_act[0] && q_cpu.size() > 0) begin
        m_cur[0] = q_cpu.pop_front(); m_act[0] = 1'b1; m_start[0] = cyc;
      end
      if (!m_act[1] && q_vec.size() > 0) begin
        m_cur[1] = q_vec.pop_front(); m_act[1] = 1'b1; m_start[1] = cyc;
      end
    end
    cpu_mem_valid = m_act[0];
    cpu_mem_addr  = m_cur[0].addr; cpu_mem_wdata = m_cur[0].wdata; cpu_mem_wstrb = m_cur[0].wstrb;
    vec_mem_valid = m_act[1];
    vec_mem_addr  = m_cur[1].addr; vec_mem_wdata = m_cur[1].wdata; vec_mem_wstrb = m_cur[1].wstrb;
    model_update();
    cyc++;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((q_cpu.size() > 0 || q_vec.size() > 0 || m_act[0] || m_act[1] || md_wait ||
            cyc < md_next_arb) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout (cycle %0d): traffic still pending after %0d cycles", cyc, budget);
    end
    step();
    step();
  endtask

  task automatic check_done(input string tag, input int idx, input bit is_vec, input int lat,
                            input logic [31:0] rdata, input bit oor);
    if (dlog.size() > idx) begin
      chk({tag, "_owner"}, {31'd0, dlog[idx].is_vec}, {31'd0, is_vec});
      chk({tag, "_latency"}, 32'(dlog[idx].done - dlog[idx].start), 32'(lat));
      chk({tag, "_rdata"}, dlog[idx].rdata, rdata);
      chk({tag, "_oor"}, {31'd0, dlog[idx].oor}, {31'd0, oor});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   b, n;
    logic [31:0] ord;
    reset = 1'b1; m_ready = 1'b0; m_rdata = 32'd0;
    cpu_mem_valid = 1'b0; vec_mem_valid = 1'b0;
    cpu_mem_addr = 32'd0; cpu_mem_wdata = 32'd0; cpu_mem_wstrb = 4'd0;
    vec_mem_addr = 32'd0; vec_mem_wdata = 32'd0; vec_mem_wstrb = 4'd0;
    m_act[0] = 1'b0; m_act[1] = 1'b0; m_cur[0] = '0; m_cur[1] = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom | 32'h1;
      ref_mem[i] = mem[i];
    end

    rst_req = 1'b1;
    repeat (3) step();
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_cpu_rdata", cpu_mem_rdata, 32'd0);
    chk("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
    rst_req = 1'b0;
    step();

    // CPU read alone, 1-wait memory
    mem[100] = 32'h04030201; ref_mem[100] = 32'h04030201;
    b = dlog.size();
    q_cpu.push_back('{32'h190, 32'h0, 4'h0});
    run_idle(40);
    chk("t1_count", 32'(dlog.size() - b), 32'd1);
    check_done("t1", b, 1'b0, 3, 32'h04030201, 1'b0);
    chk("t1_m_addr", m_addr, 32'h190);

    // Vec byte write
    mem[150] = 32'hAABBCCDD; ref_mem[150] = 32'hAABBCCDD;
    b = dlog.size();
    q_vec.push_back('{32'h258, 32'h1, 4'b0001});
    run_idle(40);
    check_done("t2", b, 1'b1, 3, 32'hAABBCCDD, 1'b0);
    chk("t2_mem", mem[150], 32'hAABBCC01);

    // Simultaneous requests: vec first, CPU four cycles later
    b = dlog.size();
    q_vec.push_back('{32'h10, 32'h0, 4'h0});
    q_cpu.push_back('{32'h20, 32'h0, 4'h0});
    run_idle(60);
    chk("t3_count", 32'(dlog.size() - b), 32'd2);
    if (dlog.size() >= b + 2) begin
      chk("t3_first_vec", {31'd0, dlog[b].is_vec}, 32'd1);
      chk("t3_gap", 32'(dlog[b+1].done - dlog[b].done), 32'd4);
    end

    // Starvation guard: 6 vec reads against 3 CPU reads
    b = dlog.size();
    for (int i = 0; i < 3; i++) q_cpu.push_back('{32'h40 + 32'(4*i), 32'h0, 4'h0});
    for (int i = 0; i < 6; i++) q_vec.push_back('{32'h80 + 32'(4*i), 32'h0, 4'h0});
    run_idle(200);
    chk("t4_count", 32'(dlog.size() - b), 32'd9);
    ord = 32'd0;
    for (int i = b; i < dlog.size(); i++) ord = (ord << 1) | {31'd0, dlog[i].is_vec};
    chk("t4_grant_order", ord, 32'h1EC);

    // Out-of-range CPU read
    b = dlog.size();
    saw_mvalid = 1'b0;
    q_cpu.push_back('{32'h400, 32'h0, 4'h0});
    run_idle(40);
    check_done("t5", b, 1'b0, 1, 32'd0, 1'b1);
    chk("t5_no_m_valid", {31'd0, saw_mvalid}, 32'd0);

    // Reset while the downstream request is outstanding, then a late m_ready
    mem_delay = 4;
    q_cpu.push_back('{32'h190, 32'h0, 4'h0});
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t6_m_valid_seen", {31'd0, m_valid}, 32'd1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("t6_m_valid_cleared", {31'd0, m_valid}, 32'd0);
    chk("t6_cpu_ready", {31'd0, cpu_mem_ready}, 32'd0);
    b = dlog.size();
    repeat (8) step();
    chk("t6_no_ready", 32'(dlog.size() - b), 32'd0);
    mem_delay = 1;
    b = dlog.size();
    q_cpu.push_back('{32'h190, 32'h0, 4'h0});
    run_idle(40);
    check_done("t6_fresh", b, 1'b0, 3, 32'h04030201, 1'b0);

    // Random traffic with variable memory latency and stray m_ready pulses
    mem_rand = 1'b1;
    mem_noise = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (q_cpu.size() == 0 && $urandom_range(0, 2) == 0) q_cpu.push_back(rand_req());
      if (q_vec.size() == 0 && $urandom_range(0, 2) == 0) q_vec.push_back(rand_req());
      step();
    end
    mem_noise = 1'b0;
    run_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
